interrupt_sequencer: RTL and testbench

Sequences the 6502 reset, NMI, IRQ and BRK entry sequences on the shared CPU datapath. It takes over from `instruction_decode` at an instruction boundary and drives the address bus, the stack-pointer and PC load strobes, and the status-register I flag. It then hands the datapath back with the PC loaded from the selected vector. It sits beside `instruction_decode`, and the top level multiplexes the two blocks' datapath controls on `busy`.

---
 rtl/interrupt_sequencer_pkg.sv | 44 ++++
 rtl/interrupt_sequencer_nmi_edge_latch.sv | 45 ++++
 rtl/interrupt_sequencer.sv | 198 +++++++++++++++++++
 tb/tb_interrupt_sequencer.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/interrupt_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer_pkg
// Shared constants for the 6502 interrupt/reset entry sequencer: vector
// addresses, sequence-kind encodings, data_out_sel codes and the stack page
// base. Also provides the kind-to-vector lookup used by the sequencer.
// -----------------------------------------------------------------------------
package interrupt_sequencer_pkg;

    // Which entry sequence is running.
    typedef enum logic [1:0] {
        KIND_RST = 2'd0,
        KIND_NMI = 2'd1,
        KIND_IRQ = 2'd2,
        KIND_BRK = 2'd3
    } kind_t;

    // Vector low-byte addresses; the high byte lives at vector + 1.
    localparam logic [15:0] VEC_NMI = 16'hFFFA;
    localparam logic [15:0] VEC_RST = 16'hFFFC;
    localparam logic [15:0] VEC_IRQ = 16'hFFFE;

    // Hardware stack lives in page 1.
    localparam logic [15:0] STACK_BASE = 16'h0100;

    // Byte the top level drives onto the data bus during a push.
    localparam logic [1:0] DSEL_NONE = 2'b00;
    localparam logic [1:0] DSEL_PCH  = 2'b01;
    localparam logic [1:0] DSEL_PCL  = 2'b10;
    localparam logic [1:0] DSEL_P    = 2'b11;

    // Low-byte vector address for a sequence kind (IRQ and BRK share one).
    function automatic logic [15:0] vector_addr(input kind_t kind);
        logic [15:0] addr;
        case (kind)
            KIND_NMI: addr = VEC_NMI;
            KIND_RST: addr = VEC_RST;
            KIND_IRQ: addr = VEC_IRQ;
            KIND_BRK: addr = VEC_IRQ;
            default:  addr = VEC_RST;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_nmi_edge_latch.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer_nmi_edge_latch
// Registers the NMI line, detects its rising edge and holds a pending flag
// until the sequencer consumes it. A new edge in the same cycle as a clear
// keeps the flag set so no NMI is lost.
// Ports:
//   i_clk      system clock
//   i_res      asynchronous active-high reset, clears sync flop and pending
//   i_nmi      raw NMI request, active-high
//   i_clr      sequencer is consuming the pending NMI this cycle
//   o_pending  an NMI edge has been seen and not yet serviced
// -----------------------------------------------------------------------------
module interrupt_sequencer_nmi_edge_latch (
    input  logic i_clk,
    input  logic i_res,
    input  logic i_nmi,
    input  logic i_clr,
    output logic o_pending
);

    logic r_nmi_q;
    logic r_pending;
    logic w_rise;

    assign w_rise    = i_nmi & ~r_nmi_q;
    assign o_pending = r_pending;

    // Sync flop and pending flag; edge set has priority over clear.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_nmi_q   <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_nmi_q <= i_nmi;
            if (w_rise) begin
                r_pending <= 1'b1;
            end else if (i_clr) begin
                r_pending <= 1'b0;
            end else begin
                r_pending <= r_pending;
            end
        end
    end

endmodule

// File: rtl/interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// interrupt_sequencer
// Runs the 6502 reset / NMI / IRQ / BRK entry sequences on the shared
// datapath: dummy read, three stack pushes (reads only for reset), then the
// two vector reads that load the PC. The top level muxes these controls
// against instruction_decode using o_busy.
// Ports:
//   i_clk, i_res           clock; async active-high reset (also requests RST)
//   i_rdy                  1 = advance, 0 = stall
//   i_irq, i_nmi           level IRQ, edge NMI
//   i_brk_req              decoder fetched BRK (valid with i_instr_boundary)
//   i_instr_boundary       opcode-fetch cycle pulse from the decoder
//   i_i_flag               current interrupt-disable bit
//   i_sp                   current stack pointer
//   o_busy                 sequencer owns the datapath
//   o_memory_address, o_rw bus address and direction
//   o_data_out_sel         byte to drive on a push (none/PCH/PCL/P)
//   o_b_flag               B bit merged into the pushed P
//   o_sp_decrement         decrement SP at end of cycle
//   o_pcl_load, o_pch_load load PC byte from the data bus
//   o_set_i_flag           set I at end of cycle
//   o_seq_done             last sequencer cycle
// -----------------------------------------------------------------------------
module interrupt_sequencer
    import interrupt_sequencer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_res,
    input  logic        i_rdy,
    input  logic        i_irq,
    input  logic        i_nmi,
    input  logic        i_brk_req,
    input  logic        i_instr_boundary,
    input  logic        i_i_flag,
    input  logic [7:0]  i_sp,
    output logic        o_busy,
    output logic [15:0] o_memory_address,
    output logic        o_rw,
    output logic [1:0]  o_data_out_sel,
    output logic        o_b_flag,
    output logic        o_sp_decrement,
    output logic        o_pcl_load,
    output logic        o_pch_load,
    output logic        o_set_i_flag,
    output logic        o_seq_done
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_T1       = 3'd1,
        S_PUSH_PCH = 3'd2,
        S_PUSH_PCL = 3'd3,
        S_PUSH_P   = 3'd4,
        S_VEC_LO   = 3'd5,
        S_VEC_HI   = 3'd6
    } state_t;

    state_t      r_state;
    state_t      w_state_next;
    kind_t       r_kind;
    kind_t       w_kind_next;
    logic        w_nmi_pending;
    logic        w_nmi_clr;
    logic [15:0] w_stack_addr;
    logic [15:0] w_vec_addr;
    logic        w_push_rw;

    interrupt_sequencer_nmi_edge_latch u_nmi_latch (
        .i_clk     (i_clk),
        .i_res     (i_res),
        .i_nmi     (i_nmi),
        .i_clr     (w_nmi_clr),
        .o_pending (w_nmi_pending)
    );

    assign w_stack_addr = STACK_BASE + {8'h00, i_sp};
    assign w_vec_addr   = vector_addr(r_kind);
    // Reset walks the stack with reads so memory is not disturbed.
    assign w_push_rw    = (r_kind == KIND_RST) ? 1'b1 : 1'b0;

    // State and kind registers; reset parks in S_T1 ready to run RST.
    always_ff @(posedge i_clk or posedge i_res) begin
        if (i_res) begin
            r_state <= S_T1;
            r_kind  <= KIND_RST;
        end else begin
            r_state <= w_state_next;
            r_kind  <= w_kind_next;
        end
    end

    // Next-state, kind selection, NMI hijack and pending-NMI consumption.
    always_comb begin
        w_state_next = r_state;
        w_kind_next  = r_kind;
        w_nmi_clr    = 1'b0;
        if (i_rdy) begin
            case (r_state)
                S_IDLE: begin
                    if (i_instr_boundary) begin
                        if (w_nmi_pending) begin
                            w_state_next = S_T1;
                            w_kind_next  = KIND_NMI;
                        end else if (i_brk_req) begin
                            w_state_next = S_T1;
                            w_kind_next  = KIND_BRK;
                        end else if (i_irq && !i_i_flag) begin
                            w_state_next = S_T1;
                            w_kind_next  = KIND_IRQ;
                        end else begin
                            w_state_next = S_IDLE;
                        end
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
                S_T1:       w_state_next = S_PUSH_PCH;
                S_PUSH_PCH: w_state_next = S_PUSH_PCL;
                S_PUSH_PCL: w_state_next = S_PUSH_P;
                S_PUSH_P: begin
                    w_state_next = S_VEC_LO;
                    // A late NMI steals the vector fetch of an IRQ/BRK.
                    if (w_nmi_pending && ((r_kind == KIND_IRQ) || (r_kind == KIND_BRK))) begin
                        w_kind_next = KIND_NMI;
                    end else begin
                        w_kind_next = r_kind;
                    end
                    if (w_kind_next == KIND_NMI) begin
                        w_nmi_clr = 1'b1;
                    end else begin
                        w_nmi_clr = 1'b0;
                    end
                end
                S_VEC_LO:   w_state_next = S_VEC_HI;
                S_VEC_HI:   w_state_next = S_IDLE;
                default:    w_state_next = S_IDLE;
            endcase
        end else begin
            w_state_next = r_state;
        end
    end

    // Datapath controls decoded from state and kind; strobes need i_rdy.
    always_comb begin
        o_busy           = 1'b1;
        o_memory_address = 16'h0000;
        o_rw             = 1'b1;
        o_data_out_sel   = DSEL_NONE;
        o_b_flag         = (r_kind == KIND_BRK) ? 1'b1 : 1'b0;
        o_sp_decrement   = 1'b0;
        o_pcl_load       = 1'b0;
        o_pch_load       = 1'b0;
        o_set_i_flag     = 1'b0;
        o_seq_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                o_busy   = 1'b0;
                o_b_flag = 1'b0;
            end
            S_T1: begin
                o_memory_address = 16'h0000;
            end
            S_PUSH_PCH: begin
                o_memory_address = w_stack_addr;
                o_rw             = w_push_rw;
                o_data_out_sel   = DSEL_PCH;
                o_sp_decrement   = i_rdy;
            end
            S_PUSH_PCL: begin
                o_memory_address = w_stack_addr;
                o_rw             = w_push_rw;
                o_data_out_sel   = DSEL_PCL;
                o_sp_decrement   = i_rdy;
            end
            S_PUSH_P: begin
                o_memory_address = w_stack_addr;
                o_rw             = w_push_rw;
                o_data_out_sel   = DSEL_P;
                o_sp_decrement   = i_rdy;
                o_set_i_flag     = i_rdy;
            end
            S_VEC_LO: begin
                o_memory_address = w_vec_addr;
                o_pcl_load       = i_rdy;
            end
            S_VEC_HI: begin
                o_memory_address = w_vec_addr + 16'h0001;
                o_pch_load       = i_rdy;
                o_seq_done       = 1'b1;
            end
            default: begin
                o_busy   = 1'b0;
                o_b_flag = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_interrupt_sequencer.sv
// -----------------------------------------------------------------------------
// tb_interrupt_sequencer
// Directed bench for interrupt_sequencer. The bench plays the role of the
// stack-pointer register: it decrements its own sp whenever the DUT strobes
// o_sp_decrement at a clock edge. Every cycle's full output word is compared
// against a hand-built expected word.
// Output word layout: {busy, addr[15:0], rw, dsel[1:0], b, spdec, pcl, pch, seti, done}
// -----------------------------------------------------------------------------
module tb_interrupt_sequencer;

    logic        clk;
    logic        res;
    logic        rdy;
    logic        irq;
    logic        nmi;
    logic        brk_req;
    logic        bnd;
    logic        i_flag;
    logic [7:0]  sp;
    logic        busy;
    logic [15:0] addr;
    logic        rw;
    logic [1:0]  dsel;
    logic        b_flag;
    logic        sp_dec;
    logic        pcl_load;
    logic        pch_load;
    logic        set_i;
    logic        done;

    int n_checks;
    int n_fails;

    interrupt_sequencer dut (
        .i_clk            (clk),
        .i_res            (res),
        .i_rdy            (rdy),
        .i_irq            (irq),
        .i_nmi            (nmi),
        .i_brk_req        (brk_req),
        .i_instr_boundary (bnd),
        .i_i_flag         (i_flag),
        .i_sp             (sp),
        .o_busy           (busy),
        .o_memory_address (addr),
        .o_rw             (rw),
        .o_data_out_sel   (dsel),
        .o_b_flag         (b_flag),
        .o_sp_decrement   (sp_dec),
        .o_pcl_load       (pcl_load),
        .o_pch_load       (pch_load),
        .o_set_i_flag     (set_i),
        .o_seq_done       (done)
    );

    // Free-running clock, period 10.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Global watchdog so the run always terminates.
    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [25:0] ev(input logic e_busy, input logic [15:0] e_addr,
                                       input logic e_rw, input logic [1:0] e_dsel,
                                       input logic e_b, input logic e_spdec,
                                       input logic e_pcl, input logic e_pch,
                                       input logic e_seti, input logic e_done);
        return {e_busy, e_addr, e_rw, e_dsel, e_b, e_spdec, e_pcl, e_pch, e_seti, e_done};
    endfunction

    function automatic logic [25:0] obs();
        return {busy, addr, rw, dsel, b_flag, sp_dec, pcl_load, pch_load, set_i, done};
    endfunction

    // Single comparison point for the whole bench.
    task automatic check_value(input string tag, input logic [25:0] got, input logic [25:0] exp);
        n_checks = n_checks + 1;
        if (got !== exp) begin
            n_fails = n_fails + 1;
            $display("FAIL %s: got %07h expected %07h", tag, got, exp);
        end
    endtask

    // Advance one clock; the bench's sp follows the DUT's decrement strobe.
    task automatic cyc();
        logic dec;
        #1;
        dec = sp_dec;
        @(posedge clk);
        #1;
        if (dec) sp = sp - 8'd1;
        #1;
    endtask

    // Check a full six-cycle sequence starting in S_T1.
    // wr = pushes are writes; b = expected B flag; vec = low vector address.
    task automatic expect_seq(input string tag, input logic [7:0] sp0, input logic wr,
                              input logic b, input logic [15:0] vec);
        logic [15:0] s0;
        s0 = {8'h01, sp0};
        check_value({tag, "_t1"},  obs(), ev(1'b1, 16'h0000, 1'b1, 2'b00, b, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc();
        check_value({tag, "_pch"}, obs(), ev(1'b1, s0, ~wr, 2'b01, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc();
        check_value({tag, "_pcl"}, obs(), ev(1'b1, s0 - 16'd1, ~wr, 2'b10, b, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc();
        check_value({tag, "_p"},   obs(), ev(1'b1, s0 - 16'd2, ~wr, 2'b11, b, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc();
        check_value({tag, "_vlo"}, obs(), ev(1'b1, vec, 1'b1, 2'b00, b, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc();
        check_value({tag, "_vhi"}, obs(), ev(1'b1, vec + 16'd1, 1'b1, 2'b00, b, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
    endtask

    logic [25:0] idle_w;
    logic [25:0] t1_w;

    initial begin
        n_checks = 0;
        n_fails  = 0;
        idle_w = ev(1'b0, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        t1_w   = ev(1'b1, 16'h0000, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        res = 1'b1; rdy = 1'b1; irq = 1'b0; nmi = 1'b0; brk_req = 1'b0;
        bnd = 1'b0; i_flag = 1'b0; sp = 8'hFD;

        // Reset values, then the reset sequence after res falls.
        repeat (3) @(posedge clk);
        #2;
        check_value("reset_values", obs(), t1_w);
        res = 1'b0;
        #1;
        expect_seq("rst", 8'hFD, 1'b0, 1'b0, 16'hFFFC);
        cyc();
        check_value("rst_idle", obs(), idle_w);

        // IRQ with I clear.
        sp = 8'hFF; irq = 1'b1; bnd = 1'b1;
        #1;
        check_value("irq_accept_cycle", obs(), idle_w);
        cyc();
        bnd = 1'b0; irq = 1'b0;
        #1;
        expect_seq("irq", 8'hFF, 1'b1, 1'b0, 16'hFFFE);
        cyc();
        check_value("irq_idle", obs(), idle_w);

        // IRQ masked by I; then BRK at the next boundary.
        irq = 1'b1; i_flag = 1'b1; bnd = 1'b1;
        cyc();
        bnd = 1'b0;
        #1;
        check_value("irq_masked", obs(), idle_w);
        bnd = 1'b1; brk_req = 1'b1;
        cyc();
        bnd = 1'b0; brk_req = 1'b0; irq = 1'b0; i_flag = 1'b0;
        #1;
        expect_seq("brk", 8'hFC, 1'b1, 1'b1, 16'hFFFE);
        cyc();
        check_value("brk_idle", obs(), idle_w);

        // NMI edge during PUSH_PCL of an IRQ hijacks the vector fetch.
        sp = 8'hFF; irq = 1'b1; bnd = 1'b1;
        cyc();
        bnd = 1'b0; irq = 1'b0;
        #1;
        check_value("hj_t1", obs(), t1_w);
        cyc();
        check_value("hj_pch", obs(), ev(1'b1, 16'h01FF, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc();
        check_value("hj_pcl", obs(), ev(1'b1, 16'h01FE, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        nmi = 1'b1;
        cyc();
        check_value("hj_p", obs(), ev(1'b1, 16'h01FD, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc();
        check_value("hj_vlo", obs(), ev(1'b1, 16'hFFFA, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc();
        check_value("hj_vhi", obs(), ev(1'b1, 16'hFFFB, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        cyc();
        check_value("hj_idle", obs(), idle_w);
        // nmi still high: pending was consumed, no retrigger at a boundary.
        bnd = 1'b1;
        cyc();
        bnd = 1'b0;
        #1;
        check_value("nmi_no_retrigger", obs(), idle_w);

        // Fresh NMI edge in idle is taken at the next boundary.
        nmi = 1'b0;
        cyc();
        nmi = 1'b1;
        cyc();
        bnd = 1'b1;
        cyc();
        bnd = 1'b0;
        #1;
        expect_seq("nmi", 8'hFC, 1'b1, 1'b0, 16'hFFFA);
        cyc();
        check_value("nmi_idle", obs(), idle_w);
        nmi = 1'b0;

        // rdy low for three cycles in PUSH_PCL: 9-cycle IRQ sequence.
        sp = 8'hFF; irq = 1'b1; bnd = 1'b1;
        cyc();
        bnd = 1'b0; irq = 1'b0;
        #1;
        check_value("st_t1", obs(), t1_w);
        cyc();
        check_value("st_pch", obs(), ev(1'b1, 16'h01FF, 1'b0, 2'b01, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc();
        rdy = 1'b0;
        #1;
        check_value("st_hold0", obs(), ev(1'b1, 16'h01FE, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        for (int k = 1; k < 3; k++) begin
            cyc();
            check_value($sformatf("st_hold%0d", k), obs(),
                        ev(1'b1, 16'h01FE, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0));
        end
        rdy = 1'b1;
        #1;
        check_value("st_pcl", obs(), ev(1'b1, 16'h01FE, 1'b0, 2'b10, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
        cyc();
        check_value("st_p", obs(), ev(1'b1, 16'h01FD, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        cyc();
        check_value("st_vlo", obs(), ev(1'b1, 16'hFFFE, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0));
        cyc();
        check_value("st_vhi", obs(), ev(1'b1, 16'hFFFF, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1));
        cyc();
        check_value("st_idle", obs(), idle_w);

        // res asserted as the IRQ enters S_VEC_LO aborts into the reset sequence.
        sp = 8'hFF; irq = 1'b1; bnd = 1'b1;
        cyc();
        bnd = 1'b0; irq = 1'b0;
        repeat (3) cyc();
        check_value("ab_p", obs(), ev(1'b1, 16'h01FD, 1'b0, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0));
        @(posedge clk);
        res = 1'b1;
        #1;
        check_value("ab_forced_t1", obs(), t1_w);
        sp = 8'hF0;
        cyc();
        check_value("ab_held_t1", obs(), t1_w);
        res = 1'b0;
        #1;
        expect_seq("ab_rst", 8'hF0, 1'b0, 1'b0, 16'hFFFC);
        cyc();
        check_value("ab_idle", obs(), idle_w);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
